// File: rtl/xdma_wr_pkg.sv
// Shared types and helpers for the C2H write batching controller.
package xdma_wr_pkg;

  // Batching controller states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    REPORT   = 3'd2,
    IRQ_DLY  = 3'd3,
    WAIT_CLR = 3'd4
  } wr_state_e;

  // Default per-packet alignment (64 B) and its address mask.
  localparam int unsigned ALIGN_LOG2_DFLT = 6;
  localparam logic [31:0] ALIGN_MASK      = ~((32'd1 << ALIGN_LOG2_DFLT) - 32'd1);

  // Mask clearing the low log2 address bits.
  function automatic logic [31:0] f_align_mask(input int unsigned log2);
    return ~((32'd1 << log2) - 32'd1);
  endfunction

  // Round a byte length up to the next 2^log2 boundary (32-bit wrap-around).
  function automatic logic [31:0] f_align_len(input logic [31:0] len, input int unsigned log2);
    logic [31:0] mask_v;
    mask_v = f_align_mask(log2);
    return (len + ~mask_v) & mask_v;
  endfunction

  // Ceiling log2 with a minimum of 1, for sizing counters.
  function automatic int f_clog2(input int unsigned val);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xdma_ring_alloc.sv
// Host ring write-pointer: aligns lengths, decides fit vs. wrap, advances on accept.
module xdma_ring_alloc
  import xdma_wr_pkg::*;
#(
  parameter logic [31:0] P_RING_BASE  = 32'h0000_0000,
  parameter logic [31:0] P_RING_SIZE  = 32'h0100_0000,
  parameter int unsigned P_ALIGN_LOG2 = 6
) (
  input  logic        i_clk_200MHz,
  input  logic        i_rst_200MHz,
  input  logic [31:0] i_len,
  input  logic        i_accept,
  output logic [31:0] o_addr,
  output logic [31:0] o_alen,
  output logic        o_fits,
  output logic        o_oversize
);

  localparam logic [31:0] RING_END = P_RING_BASE + P_RING_SIZE;

  logic [31:0] cur_addr_q;
  logic [31:0] cur_addr_d;
  logic [31:0] alen_s;
  logic [31:0] addr_s;
  logic [31:0] next_s;
  logic        fits_s;
  logic        oversize_s;

  // Placement of the presented packet: current pointer if it fits, else ring base.
  always_comb begin
    alen_s     = f_align_len(i_len, P_ALIGN_LOG2);
    oversize_s = (alen_s > P_RING_SIZE);
    fits_s     = ((cur_addr_q + alen_s) <= RING_END);
    addr_s     = fits_s ? cur_addr_q : P_RING_BASE;
  end

  // Pointer advance; landing exactly on the ring end folds back to the base.
  always_comb begin
    next_s = addr_s + alen_s;
    if (i_accept && !oversize_s) begin
      if (next_s == RING_END) begin
        cur_addr_d = P_RING_BASE;
      end else begin
        cur_addr_d = next_s;
      end
    end else begin
      cur_addr_d = cur_addr_q;
    end
  end

  // Write-pointer register.
  always_ff @(posedge i_clk_200MHz or posedge i_rst_200MHz) begin
    if (i_rst_200MHz) begin
      cur_addr_q <= P_RING_BASE;
    end else begin
      cur_addr_q <= cur_addr_d;
    end
  end

  assign o_addr     = addr_s;
  assign o_alen     = alen_s;
  assign o_fits     = fits_s;
  assign o_oversize = oversize_s;

endmodule

// File: rtl/xdma_wr_batch_ctrl.sv
// Groups C2H packet descriptors into contiguous host-ring batches, reports each
// batch to the BAR control block and raises the user interrupt until cleared.
module xdma_wr_batch_ctrl
  import xdma_wr_pkg::*;
#(
  parameter logic [31:0] P_RING_BASE  = 32'h0000_0000,
  parameter logic [31:0] P_RING_SIZE  = 32'h0100_0000,
  parameter int unsigned P_ALIGN_LOG2 = 6,
  parameter int unsigned P_BATCH_MAX  = 16,
  parameter int unsigned P_TIMEOUT    = 2000,
  parameter int unsigned P_IRQ_DLY    = 16
) (
  input  logic        i_clk_200MHz,
  input  logic        i_rst_200MHz,
  input  logic        i_pkt_valid,
  output logic        o_pkt_ready,
  input  logic [31:0] i_pkt_len,
  input  logic [7:0]  i_pkt_stream_id,
  output logic [31:0] o_pkt_addr,
  output logic [31:0] o_bar_addr,
  output logic [31:0] o_bar_len,
  output logic        o_bar_valid,
  output logic [7:0]  o_stream_id,
  output logic        o_stream_valid,
  output logic        o_usr_irq_req,
  input  logic        i_interrupt_clear,
  output logic        o_err_oversize
);

  localparam int CNT_W = f_clog2(P_BATCH_MAX + 1);
  localparam int TMR_W = f_clog2(P_TIMEOUT + 1);
  localparam int DLY_W = f_clog2(P_IRQ_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_BATCH_MAX - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(P_TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(P_IRQ_DLY - 1);

  wr_state_e   state_q, state_d;
  logic [31:0] batch_addr_q, batch_addr_d;
  logic [31:0] batch_len_q, batch_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [31:0] bar_addr_q, bar_addr_d;
  logic [31:0] bar_len_q, bar_len_d;
  logic        bar_valid_q, bar_valid_d;
  logic [7:0]  stream_id_q, stream_id_d;
  logic        stream_valid_q, stream_valid_d;
  logic        irq_q, irq_d;
  logic        err_q, err_d;
  logic        run_q, run_d;

  logic [31:0] addr_s;
  logic [31:0] alen_s;
  logic        fits_s;
  logic        oversize_s;
  logic        ready_s;
  logic        accept_s;

  xdma_ring_alloc #(
    .P_RING_BASE  (P_RING_BASE),
    .P_RING_SIZE  (P_RING_SIZE),
    .P_ALIGN_LOG2 (P_ALIGN_LOG2)
  ) u_ring_alloc (
    .i_clk_200MHz (i_clk_200MHz),
    .i_rst_200MHz (i_rst_200MHz),
    .i_len        (i_pkt_len),
    .i_accept     (accept_s),
    .o_addr       (addr_s),
    .o_alen       (alen_s),
    .o_fits       (fits_s),
    .o_oversize   (oversize_s)
  );

  // Descriptor acceptance; oversize packets are always taken so they can be flagged and dropped.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      IDLE:    ready_s = run_q;
      COLLECT: ready_s = fits_s | oversize_s;
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s = i_pkt_valid & ready_s;

  // Next-state and registered-output logic of the batching FSM.
  always_comb begin
    state_d        = state_q;
    batch_addr_d   = batch_addr_q;
    batch_len_d    = batch_len_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    dly_d          = dly_q;
    run_d          = 1'b1;
    err_d          = err_q | (accept_s & oversize_s);
    stream_valid_d = accept_s & ~oversize_s;
    stream_id_d    = stream_valid_d ? i_pkt_stream_id : stream_id_q;

    case (state_q)
      IDLE: begin
        if (accept_s && !oversize_s) begin
          batch_addr_d = addr_s;
          batch_len_d  = alen_s;
          cnt_d        = CNT_W'(1);
          timer_d      = '0;
          if (P_BATCH_MAX == 1) begin
            state_d = REPORT;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (accept_s) begin
          if (!oversize_s) begin
            batch_len_d = batch_len_q + alen_s;
            cnt_d       = cnt_q + 1'b1;
            timer_d     = '0;
            if (cnt_q == CNT_LAST) begin
              state_d = REPORT;
            end else begin
              state_d = COLLECT;
            end
          end else begin
            state_d = COLLECT;
          end
        end else if (i_pkt_valid) begin
          // A valid packet that was refused does not fit: close the batch, it stays pending.
          state_d = REPORT;
        end else if (timer_q == TMR_LAST) begin
          state_d = REPORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPORT: begin
        // The REPORT cycle is the first delay cycle, so the irq lands P_IRQ_DLY after the strobe.
        state_d = IRQ_DLY;
        dly_d   = DLY_W'(1);
      end
      IRQ_DLY: begin
        if (dly_q >= DLY_LAST) begin
          state_d = WAIT_CLR;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      WAIT_CLR: begin
        if (i_interrupt_clear) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_CLR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bar_valid_d = (state_d == REPORT);
    bar_addr_d  = bar_valid_d ? batch_addr_d : bar_addr_q;
    bar_len_d   = bar_valid_d ? batch_len_d : bar_len_q;
    irq_d       = (state_d == WAIT_CLR);
  end

  // State and output registers.
  always_ff @(posedge i_clk_200MHz or posedge i_rst_200MHz) begin
    if (i_rst_200MHz) begin
      state_q        <= IDLE;
      batch_addr_q   <= 32'h0000_0000;
      batch_len_q    <= 32'h0000_0000;
      cnt_q          <= '0;
      timer_q        <= '0;
      dly_q          <= '0;
      bar_addr_q     <= 32'h0000_0000;
      bar_len_q      <= 32'h0000_0000;
      bar_valid_q    <= 1'b0;
      stream_id_q    <= 8'h00;
      stream_valid_q <= 1'b0;
      irq_q          <= 1'b0;
      err_q          <= 1'b0;
      run_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      batch_addr_q   <= batch_addr_d;
      batch_len_q    <= batch_len_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      dly_q          <= dly_d;
      bar_addr_q     <= bar_addr_d;
      bar_len_q      <= bar_len_d;
      bar_valid_q    <= bar_valid_d;
      stream_id_q    <= stream_id_d;
      stream_valid_q <= stream_valid_d;
      irq_q          <= irq_d;
      err_q          <= err_d;
      run_q          <= run_d;
    end
  end

  assign o_pkt_ready    = ready_s;
  assign o_pkt_addr     = addr_s;
  assign o_bar_addr     = bar_addr_q;
  assign o_bar_len      = bar_len_q;
  assign o_bar_valid    = bar_valid_q;
  assign o_stream_id    = stream_id_q;
  assign o_stream_valid = stream_valid_q;
  assign o_usr_irq_req  = irq_q;
  assign o_err_oversize = err_q;

endmodule

// File: tb/tb_xdma_wr_batch_ctrl.sv
// Scoreboard bench for xdma_wr_batch_ctrl with a 4 KiB ring.
`timescale 1ns/100ps
module tb_xdma_wr_batch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [31:0] pkt_len = 32'h0;
  logic [7:0]  pkt_id = 8'h0;
  logic        irq_clear = 1'b0;
  logic        o_pkt_ready;
  logic [31:0] o_pkt_addr;
  logic [31:0] o_bar_addr;
  logic [31:0] o_bar_len;
  logic        o_bar_valid;
  logic [7:0]  o_stream_id;
  logic        o_stream_valid;
  logic        o_usr_irq_req;
  logic        o_err_oversize;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_stream_q[$];
  logic [63:0] exp_bar_q[$];

  xdma_wr_batch_ctrl #(
    .P_RING_BASE (32'h0000_0000),
    .P_RING_SIZE (32'h0000_1000)
  ) dut (
    .i_clk_200MHz      (clk),
    .i_rst_200MHz      (rst),
    .i_pkt_valid       (pkt_valid),
    .o_pkt_ready       (o_pkt_ready),
    .i_pkt_len         (pkt_len),
    .i_pkt_stream_id   (pkt_id),
    .o_pkt_addr        (o_pkt_addr),
    .o_bar_addr        (o_bar_addr),
    .o_bar_len         (o_bar_len),
    .o_bar_valid       (o_bar_valid),
    .o_stream_id       (o_stream_id),
    .o_stream_valid    (o_stream_valid),
    .o_usr_irq_req     (o_usr_irq_req),
    .i_interrupt_clear (irq_clear),
    .o_err_oversize    (o_err_oversize)
  );

  always #2.5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever a strobe is presented.
  always @(negedge clk) begin
    if (o_stream_valid) begin
      if (exp_stream_q.size() == 0) begin
        chk("stream_unexpected", 64'(o_stream_id), 64'hDEAD);
      end else begin
        chk("stream_id", 64'(o_stream_id), 64'(exp_stream_q.pop_front()));
      end
    end
    if (o_bar_valid) begin
      if (exp_bar_q.size() == 0) begin
        chk("bar_unexpected", {o_bar_addr, o_bar_len}, 64'hDEAD);
      end else begin
        chk("bar_addr_len", {o_bar_addr, o_bar_len}, exp_bar_q.pop_front());
      end
    end
  end

  // Present a packet (caller is just after a posedge); returns just after the accepting posedge.
  task automatic send(input logic [31:0] len, input logic [7:0] id, input logic [31:0] exp_addr,
                      input bit chk_addr, input bit exp_stream);
    int n;
    n = 0;
    pkt_valid = 1'b1;
    pkt_len   = len;
    pkt_id    = id;
    @(negedge clk);
    while (!o_pkt_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_pkt_ready) begin
      chk("ready_timeout", 64'(o_pkt_ready), 64'd1);
    end else begin
      if (chk_addr) chk("pkt_addr", 64'(o_pkt_addr), 64'(exp_addr));
      if (exp_stream) exp_stream_q.push_back(id);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    pkt_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // Wait for the batch strobe within [lo,hi] negedges, then the irq exactly 16 later;
  // optionally pulse the clear clr_at cycles after the strobe (must be ignored).
  task automatic wait_irq(input int lo, input int hi, input int clr_at);
    int n;
    int m;
    bit ready_seen;
    bit irq_drop;
    n = 0;
    m = 0;
    ready_seen = 1'b0;
    irq_drop = 1'b0;
    @(negedge clk);
    while (!o_bar_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("bar_seen", 64'(o_bar_valid), 64'd1);
    chk("bar_timing_ok", 64'((n >= lo) && (n <= hi)), 64'd1);
    while (!o_usr_irq_req && m < 100) begin
      irq_clear = (m == clr_at);
      @(negedge clk);
      m++;
      if (o_pkt_ready) ready_seen = 1'b1;
    end
    irq_clear = 1'b0;
    chk("irq_delay", 64'(m), 64'd16);
    repeat (8) begin
      @(negedge clk);
      if (!o_usr_irq_req) irq_drop = 1'b1;
      if (o_pkt_ready) ready_seen = 1'b1;
    end
    chk("irq_held", 64'(irq_drop), 64'd0);
    chk("ready_low_until_clear", 64'(ready_seen), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    @(posedge clk); #1;
    irq_clear = 1'b0;
    chk("irq_cleared", 64'(o_usr_irq_req), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset state.
    #1;
    chk("rst_ready", 64'(o_pkt_ready), 64'd0);
    chk("rst_bar_valid", 64'(o_bar_valid), 64'd0);
    chk("rst_stream_valid", 64'(o_stream_valid), 64'd0);
    chk("rst_irq", 64'(o_usr_irq_req), 64'd0);
    chk("rst_err", 64'(o_err_oversize), 64'd0);
    chk("rst_bar_addr_len", {o_bar_addr, o_bar_len}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single packet, closed by timeout.
    send(32'd100, 8'hA5, 32'h0, 1'b1, 1'b1);
    idle(1);
    exp_bar_q.push_back({32'h0, 32'h80});
    wait_irq(1995, 2005, -1);
    clear_irq();
    send(32'd64, 8'h11, 32'h80, 1'b1, 1'b1);
    idle(3);

    // Reset mid-batch: batch discarded, pointer back to base.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // 16 back-to-back packets fill a batch.
    exp_bar_q.push_back({32'h0, 32'h400});
    for (int i = 0; i < 16; i++) begin
      send(32'd64, 8'(i), 32'(i * 64), 1'b1, 1'b1);
    end
    pkt_valid = 1'b0;
    wait_irq(0, 0, -1);
    clear_irq();

    // Non-fitting packet in COLLECT closes the batch and wraps after clear.
    send(32'hB80, 8'h30, 32'h400, 1'b1, 1'b1);
    exp_bar_q.push_back({32'h400, 32'hB80});
    pkt_valid = 1'b1;
    pkt_len   = 32'h100;
    pkt_id    = 8'h31;
    @(negedge clk);
    chk("blocked_ready", 64'(o_pkt_ready), 64'd0);
    wait_irq(0, 0, -1);
    clear_irq();
    send(32'h100, 8'h31, 32'h0, 1'b1, 1'b1);

    // Oversize packet: accepted, flagged, no stream ID, pointer unchanged.
    send(32'h2000, 8'h32, 32'h0, 1'b0, 1'b0);
    chk("err_oversize", 64'(o_err_oversize), 64'd1);
    send(32'h40, 8'h33, 32'h100, 1'b1, 1'b1);
    idle(1);
    exp_bar_q.push_back({32'h0, 32'h140});
    // Clear pulsed during the irq delay is ignored.
    wait_irq(1995, 2005, 4);
    clear_irq();
    chk("err_sticky", 64'(o_err_oversize), 64'd1);

    // Reset while waiting for the clear.
    send(32'h40, 8'h40, 32'h140, 1'b1, 1'b1);
    idle(1);
    exp_bar_q.push_back({32'h140, 32'h40});
    wait_irq(1995, 2005, -1);
    rst = 1'b1;
    #1;
    chk("rst2_irq", 64'(o_usr_irq_req), 64'd0);
    chk("rst2_strobes", {62'd0, o_bar_valid, o_stream_valid}, 64'd0);
    chk("rst2_err", 64'(o_err_oversize), 64'd0);
    idle(3);
    rst = 1'b0;

    // Zero-length packet counts but does not move the pointer.
    send(32'd0, 8'h50, 32'h0, 1'b1, 1'b1);
    send(32'd64, 8'h51, 32'h0, 1'b1, 1'b1);
    idle(1);
    exp_bar_q.push_back({32'h0, 32'h40});
    wait_irq(1995, 2005, -1);
    clear_irq();
    idle(4);

    chk("stream_q_empty", 64'(exp_stream_q.size()), 64'd0);
    chk("bar_q_empty", 64'(exp_bar_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xdma_wr_batch_ctrl.md
Name: xdma_wr_batch_ctrl

Overview:
- 200 MHz stage directly upstream of the BAR control block. Allocates host-ring write addresses to incoming packet descriptors from the C2H write engine.
- Groups accepted packets into contiguous batches. Emits one bar addr/len record per batch and one stream ID per packet, feeding the BAR control block's async FIFOs.
- Raises the user interrupt toward XDMA and holds it until the host's interrupt-clear pulse returns.

Parameters:
- P_RING_BASE, 32'h0000_0000, host ring start byte address; must be 2^P_ALIGN_LOG2 aligned.
- P_RING_SIZE, 32'h0100_0000, ring size in bytes; must be a multiple of the alignment.
- P_ALIGN_LOG2, 6, log2 of the per-packet address alignment in bytes.
- P_BATCH_MAX, 16, packets per batch; must be ≤ 64 (stream-ID FIFO depth).
- P_TIMEOUT, 2000, idle cycles in COLLECT before a partial batch is closed.
- P_IRQ_DLY, 16, cycles from o_bar_valid to o_usr_irq_req; covers CDC FIFO latency.

Ports:
- i_clk_200MHz  in  1  clock
- i_rst_200MHz  in  1  reset
- i_pkt_valid  in  1  packet descriptor valid
- o_pkt_ready  out  1  descriptor accept
- i_pkt_len  in  32  packet length in bytes
- i_pkt_stream_id  in  8  stream ID of the packet
- o_pkt_addr  out  32  assigned host address; valid combinationally with o_pkt_ready
- o_bar_addr  out  32  batch start address
- o_bar_len  out  32  batch length in bytes (sum of aligned lengths)
- o_bar_valid  out  1  one-cycle batch record strobe
- o_stream_id  out  8  stream ID of an accepted packet
- o_stream_valid  out  1  one-cycle stream-ID strobe
- o_usr_irq_req  out  1  interrupt request to XDMA, level
- i_interrupt_clear  in  1  single-cycle clear pulse from the BAR control block
- o_err_oversize  out  1  sticky flag: packet longer than the ring

Behaviour:
- Reset: i_rst_200MHz, asynchronous, active-high; clock i_clk_200MHz.
  - All outputs 0.
  - cur_addr = P_RING_BASE; state = IDLE; all counters 0.
- Arithmetic:
  - alen = (i_pkt_len + 2^A − 1) with the low A bits cleared; A = P_ALIGN_LOG2. All arithmetic is 32-bit.
  - fits = (cur_addr + alen ≤ P_RING_BASE + P_RING_SIZE).
  - o_pkt_addr = fits ? cur_addr : P_RING_BASE.
  - On accept: cur_addr = o_pkt_addr + alen. A result equal to ring end is stored as P_RING_BASE.
- Accept = i_pkt_valid & o_pkt_ready. o_pkt_ready may depend on i_pkt_valid and i_pkt_len.
- IDLE:
  - o_pkt_ready = 1.
  - On accept: batch_addr = o_pkt_addr, batch_len = alen, cnt = 1, timer = 0.
  - If P_BATCH_MAX == 1, go to REPORT; otherwise go to COLLECT.
- COLLECT:
  - o_pkt_ready = fits. A non-fitting valid packet is not accepted and the state goes to REPORT; the packet stays pending.
  - On accept: batch_len += alen; cnt += 1; timer = 0. When cnt+1 == P_BATCH_MAX, go to REPORT.
  - With no accept: timer += 1. timer == P_TIMEOUT−1 → REPORT.
- REPORT:
  - o_pkt_ready = 0.
  - o_bar_valid = 1 for exactly one cycle, with o_bar_addr = batch_addr and o_bar_len = batch_len.
  - Next state IRQ_DLY, dly = 0.
- IRQ_DLY:
  - o_pkt_ready = 0; dly counts up.
  - dly == P_IRQ_DLY−1 → WAIT_CLR with o_usr_irq_req = 1.
  - i_interrupt_clear is ignored in this state.
- WAIT_CLR:
  - o_pkt_ready = 0; o_usr_irq_req held at 1.
  - On i_interrupt_clear: o_usr_irq_req = 0 next cycle; go to IDLE.
  - cur_addr is retained; the ring continues.
- Stream IDs: on every accepted non-oversize packet, o_stream_valid = 1 and o_stream_id = i_pkt_stream_id, registered one cycle after accept. Order equals accept order.
- Oversize packet (alen > P_RING_SIZE):
  - Accepted in IDLE or COLLECT.
  - o_err_oversize set (sticky until reset).
  - No stream ID emitted; cur_addr, batch_len, cnt and timer unchanged. o_pkt_addr is don't-care.
- Zero-length packet: accepted; alen = 0; counts toward cnt; stream ID emitted.
- i_interrupt_clear outside WAIT_CLR has no effect.
- Reset mid-batch discards the batch; no o_bar_valid is emitted.

Decomposition:
- Package xdma_wr_pkg:
  - state enum {IDLE, COLLECT, REPORT, IRQ_DLY, WAIT_CLR}
  - ALIGN_MASK constant
  - function f_align_len(len, log2)
  - function f_clog2 for counter widths
- Sub-module xdma_ring_alloc holds cur_addr and the fits/wrap/align logic. Inputs: len, accept. Outputs: addr, fits, alen, oversize.
- The batching FSM stays at top level.

Test Plan:
- Reset, single packet len 100 → o_pkt_addr 0x0. Then:
  - 2000 idle cycles later: o_bar_valid, addr 0x0, len 0x80.
  - o_usr_irq_req 16 cycles after that.
  - Clear pulse → irq low; next packet gets addr 0x80.
- 16 back-to-back packets, len 64, ids 0..15 → addrs 0x0..0x3C0 step 0x40; stream IDs 0..15 in order; o_bar_len 0x400; o_pkt_ready 0 until clear.
- P_RING_SIZE 0x1000, cur_addr 0xF80, packet len 0x100 in COLLECT:
  - Not accepted; batch closes.
  - After clear, the packet is accepted at 0x0; cur_addr 0x100.
- Packet len 0x2000 with ring 0x1000 → accepted, o_err_oversize = 1, no o_stream_valid, next packet gets the unchanged cur_addr.
- i_interrupt_clear pulsed during IRQ_DLY → ignored; irq asserts and stays until a second pulse in WAIT_CLR.
- Assert reset during WAIT_CLR → irq 0, all strobes 0, next packet addr P_RING_BASE.
